// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared types and constants for the I2S DAC transmit path
package i2s_tx_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int SAMPLE_W    = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LEFT  = ST_LEFT,
    RIGHT = ST_RIGHT
  } tx_state_t;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_t;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - stereo frame FIFO with occupancy level; DEPTH must be a power of 2
module sample_fifo
  import i2s_tx_pkg::*;
#(
  parameter int W     = 2 * SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  pop_data,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S playback serialiser for the WM8731, codec is BCLK/LRCK master.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module i2s_dac_tx
  import i2s_tx_pkg::*;
#(
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit HOLD_LAST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bclk,
  input  logic                          dac_lrck,
  output logic                          dac_dat,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [N-1:0]           s_left,
  input  logic signed [N-1:0]           s_right,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(N + 1);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_prev;
  logic                   lrck_prev;
  logic                   bclk_fall;
  logic                   lrck_fall;
  logic                   lrck_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], dac_lrck};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      lrck_prev <= lrck_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_fall = bclk_prev & ~bclk_sync[SYNC_STAGES-1];
  assign lrck_fall = lrck_prev & ~lrck_sync[SYNC_STAGES-1];
  assign lrck_rise = ~lrck_prev & lrck_sync[SYNC_STAGES-1];

  logic [2*N-1:0] fifo_dout;
  logic [2*N-1:0] last_frame;
  logic [2*N-1:0] fill_frame;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  assign s_ready    = (fifo_level != LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push       = s_valid & s_ready;
  assign pop        = lrck_fall & ~fifo_empty;
  assign fill_frame = HOLD_LAST ? last_frame : '0;

  sample_fifo #(
    .W     (2 * N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({s_left, s_right}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .level     (fifo_level)
  );

  tx_state_t      state;
  logic [CW-1:0]  bit_cnt;
  logic [N-1:0]   left_sr;
  logic [N-1:0]   right_sr;

  // LRCK edges win over a coincident bclk_fall, which becomes the I2S delay slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      left_sr    <= '0;
      right_sr   <= '0;
      last_frame <= '0;
      dac_dat    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (lrck_fall) begin
        state   <= LEFT;
        bit_cnt <= '0;
        if (!fifo_empty) begin
          {left_sr, right_sr} <= fifo_dout;
          last_frame          <= fifo_dout;
        end else begin
          {left_sr, right_sr} <= fill_frame;
          underrun            <= 1'b1;
        end
      end else if (lrck_rise && state != IDLE) begin
        state   <= RIGHT;
        bit_cnt <= '0;
      end else if (bclk_fall && state != IDLE) begin
        if (bit_cnt < CW'(N)) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (state == LEFT) begin
            dac_dat <= left_sr[N-1];
            left_sr <= left_sr << 1;
          end else begin
            dac_dat  <= right_sr[N-1];
            right_sr <= right_sr << 1;
          end
        end else begin
          dac_dat <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (underrun && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed bench: codec-master BCLK=clk/6, two DUTs (HOLD_LAST 0 and 1)
module tb_i2s_dac_tx;
  import i2s_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b1;
  logic        dac_lrck = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;

  logic        dac_dat0, dac_dat1;
  logic        s_ready0, s_ready1;
  logic        underrun0, underrun1;
  logic [2:0]  level0, level1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucount0, ucount1;
`endif

  int errors = 0;
  int checks = 0;
  int urun0 = 0;
  int urun1 = 0;

  always #5 clk = ~clk;

  i2s_dac_tx #(.N(16), .FIFO_DEPTH(4), .HOLD_LAST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bclk(bclk), .dac_lrck(dac_lrck), .dac_dat(dac_dat0),
    .s_valid(s_valid), .s_ready(s_ready0), .s_left(s_left), .s_right(s_right),
    .underrun(underrun0), .fifo_level(level0)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_count(ucount0)
`endif
  );

  i2s_dac_tx #(.N(16), .FIFO_DEPTH(4), .HOLD_LAST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bclk(bclk), .dac_lrck(dac_lrck), .dac_dat(dac_dat1),
    .s_valid(s_valid), .s_ready(s_ready1), .s_left(s_left), .s_right(s_right),
    .underrun(underrun1), .fifo_level(level1)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_count(ucount1)
`endif
  );

  always @(negedge clk) begin
    if (underrun0 === 1'b1) urun0++;
    if (underrun1 === 1'b1) urun1++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; bclk = 1'b1; dac_lrck = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_frame(input stereo_t f);
    @(negedge clk);
    s_left = f.l; s_right = f.r; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // One BCLK period per iteration; LRCK changes with the falling edge, dac_dat sampled at the rise.
  task automatic run_slot(input logic lr, input int nb, output logic [31:0] v0, output logic [31:0] v1);
    v0 = '0; v1 = '0;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      bclk = 1'b0; dac_lrck = lr;
      repeat (3) @(negedge clk);
      v0 = {v0[30:0], dac_dat0};
      v1 = {v1[30:0], dac_dat1};
      bclk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (dac_dat0 !== 1'b0) begin errors++; $display("FAIL reset_dac_dat: got %b exp 0", dac_dat0); end
    checks++; if (underrun0 !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", underrun0); end
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level0); end
    checks++; if (s_ready0 !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b exp 1", s_ready0); end
    checks++; if (dac_dat1 !== 1'b0 || level1 !== 3'd0) begin errors++; $display("FAIL reset_dut1: dac_dat %b level %0d exp 0 0", dac_dat1, level1); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [31:0] l0, l1, r0, r1, d0, d1;
    int u0;
    do_reset();
    push_frame(stereo_t'({16'hA5C3, 16'h0F0F}));
    checks++; if (level0 !== 3'd1) begin errors++; $display("FAIL basic_level_push: got %0d exp 1", level0); end
    u0 = urun0;
    run_slot(1'b1, 2, d0, d1);
    checks++; if (d0[1:0] !== 2'b00) begin errors++; $display("FAIL basic_idle_quiet: got %b exp 00", d0[1:0]); end
    run_slot(1'b0, 32, l0, l1);
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL basic_level_pop: got %0d exp 0", level0); end
    checks++; if (l0[30:15] !== 16'hA5C3) begin errors++; $display("FAIL basic_left: got %h exp a5c3", l0[30:15]); end
    checks++; if (l0[14:0] !== 15'h0) begin errors++; $display("FAIL basic_left_pad: got %h exp 0", l0[14:0]); end
    run_slot(1'b1, 32, r0, r1);
    checks++; if (r0[31] !== 1'b0) begin errors++; $display("FAIL basic_left_bit32: got %b exp 0", r0[31]); end
    checks++; if (r0[30:15] !== 16'h0F0F) begin errors++; $display("FAIL basic_right: got %h exp 0f0f", r0[30:15]); end
    checks++; if (r0[14:0] !== 15'h0) begin errors++; $display("FAIL basic_right_pad: got %h exp 0", r0[14:0]); end
    checks++; if (urun0 - u0 !== 0) begin errors++; $display("FAIL basic_no_underrun: got %0d exp 0", urun0 - u0); end
  endtask

  task automatic test_underrun_zero();
    logic [31:0] l0, l1, r0, r1, acc0, acc1;
    int u0, u1;
    do_reset();
    acc0 = '0; acc1 = '0;
    u0 = urun0; u1 = urun1;
    for (int f = 0; f < 10; f++) begin
      run_slot(1'b0, 32, l0, l1);
      run_slot(1'b1, 32, r0, r1);
      acc0 = acc0 | l0 | r0;
      acc1 = acc1 | l1 | r1;
    end
    checks++; if (acc0 !== 32'h0) begin errors++; $display("FAIL urun_zero_data0: got %h exp 0", acc0); end
    checks++; if (acc1 !== 32'h0) begin errors++; $display("FAIL urun_zero_data1: got %h exp 0", acc1); end
    checks++; if (urun0 - u0 !== 10) begin errors++; $display("FAIL urun_pulses0: got %0d exp 10", urun0 - u0); end
    checks++; if (urun1 - u1 !== 10) begin errors++; $display("FAIL urun_pulses1: got %0d exp 10", urun1 - u1); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checks++; if (ucount0 !== 16'd10) begin errors++; $display("FAIL urun_count: got %0d exp 10", ucount0); end
`endif
  endtask

  task automatic test_hold_last();
    logic [31:0] l0, l1, r0, r1;
    int u0, u1;
    do_reset();
    push_frame(stereo_t'({16'h8001, 16'h7FFE}));
    u0 = urun0; u1 = urun1;
    run_slot(1'b1, 2, l0, l1);
    for (int f = 0; f < 3; f++) begin
      run_slot(1'b0, 32, l0, l1);
      run_slot(1'b1, 32, r0, r1);
      checks++; if (l1[30:15] !== 16'h8001) begin errors++; $display("FAIL hold_left_f%0d: got %h exp 8001", f, l1[30:15]); end
      checks++; if (r1[30:15] !== 16'h7FFE) begin errors++; $display("FAIL hold_right_f%0d: got %h exp 7ffe", f, r1[30:15]); end
      if (f == 0) begin
        checks++; if (urun1 - u1 !== 0) begin errors++; $display("FAIL hold_first_no_urun: got %0d exp 0", urun1 - u1); end
      end else begin
        checks++; if ((l0 | r0) !== 32'h0) begin errors++; $display("FAIL zero_fill_f%0d: got %h exp 0", f, l0 | r0); end
      end
    end
    checks++; if (urun1 - u1 !== 2) begin errors++; $display("FAIL hold_urun1: got %0d exp 2", urun1 - u1); end
    checks++; if (urun0 - u0 !== 2) begin errors++; $display("FAIL hold_urun0: got %0d exp 2", urun0 - u0); end
  endtask

  task automatic test_backpressure();
    int nxfer;
    do_reset();
    nxfer = 0;
    s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222;
    for (int k = 0; k < 8; k++) begin
      if (s_ready0) nxfer++;
      @(negedge clk);
    end
    checks++; if (nxfer !== 4) begin errors++; $display("FAIL bp_transfers: got %0d exp 4", nxfer); end
    checks++; if (level0 !== 3'd4) begin errors++; $display("FAIL bp_level_full: got %0d exp 4", level0); end
    checks++; if (s_ready0 !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b exp 0", s_ready0); end
    dac_lrck = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (level0 !== 3'd3 || s_ready0 !== 1'b1) begin errors++; $display("FAIL bp_after_pop: level %0d ready %b exp 3 1", level0, s_ready0); end
    @(negedge clk);
    checks++; if (level0 !== 3'd4 || s_ready0 !== 1'b0) begin errors++; $display("FAIL bp_refill: level %0d ready %b exp 4 0", level0, s_ready0); end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] l0, l1, r0, r1;
    do_reset();
    push_frame(stereo_t'({16'hFFFF, 16'h0000}));
    push_frame(stereo_t'({16'hFFFF, 16'h0000}));
    run_slot(1'b1, 2, l0, l1);
    run_slot(1'b0, 8, l0, l1);
    checks++; if (l0[7:0] !== 8'h7F) begin errors++; $display("FAIL rstmid_seven_bits: got %h exp 7f", l0[7:0]); end
    rst = 1'b1;
    #1;
    checks++; if (dac_dat0 !== 1'b0 || level0 !== 3'd0 || s_ready0 !== 1'b1) begin
      errors++; $display("FAIL rstmid_immediate: dac_dat %b level %0d ready %b exp 0 0 1", dac_dat0, level0, s_ready0);
    end
    @(negedge clk);
    rst = 1'b0;
    push_frame(stereo_t'({16'h1234, 16'h5678}));
    run_slot(1'b1, 32, r0, r1);
    checks++; if (r0 !== 32'h0) begin errors++; $display("FAIL rstmid_rise_ignored: got %h exp 0", r0); end
    checks++; if (level0 !== 3'd1) begin errors++; $display("FAIL rstmid_no_pop: got %0d exp 1", level0); end
    run_slot(1'b0, 32, l0, l1);
    checks++; if (l0[30:15] !== 16'h1234) begin errors++; $display("FAIL rstmid_restart: got %h exp 1234", l0[30:15]); end
  endtask

  task automatic test_short_slot();
    logic [31:0] l0, l1, r0, r1;
    do_reset();
    push_frame(stereo_t'({16'hFFFF, 16'hA5C3}));
    run_slot(1'b1, 2, l0, l1);
    run_slot(1'b0, 12, l0, l1);
    checks++; if (l0[11:0] !== 12'h7FF) begin errors++; $display("FAIL short_left: got %h exp 7ff", l0[11:0]); end
    run_slot(1'b1, 32, r0, r1);
    checks++; if (r0[31] !== 1'b1) begin errors++; $display("FAIL short_delay_slot: got %b exp 1", r0[31]); end
    checks++; if (r0[30:15] !== 16'hA5C3) begin errors++; $display("FAIL short_right: got %h exp a5c3", r0[30:15]); end
    checks++; if (r0[14:0] !== 15'h0) begin errors++; $display("FAIL short_right_pad: got %h exp 0", r0[14:0]); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun_zero();
    test_hold_last();
    test_backpressure();
    test_reset_mid_frame();
    test_short_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
